quad_input_stage: RTL and testbench
===================================

# quad_input_stage

Per-channel encoder front end that sits directly upstream of the counter core in hdlcounter. It synchronises the raw quadrature pins, applies a per-bit noise filter, and decodes the filtered Gray code into single-cycle increment/decrement pulses for the position counter. It also flags illegal two-step transitions. One instance per encoder channel. `FILTER` and `FULL` replace the per-channel filter-size and quad-full settings.

## Interface
Parameters:
- FILTER, 4: consecutive mismatching samples required before a filtered bit updates; legal range 1..15.
- FULL, 1: 1 = count every edge (x4); 0 = one count per full quadrature cycle (x1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- q  in  2  raw encoder pins, asynchronous to clk.
- err_clr  in  1  clears sticky error flag.
- inc  out  1  one-cycle pulse per forward count.
- dec  out  1  one-cycle pulse per reverse count.
- err  out  1  sticky illegal-transition flag.
- q_filt  out  2  filtered pin state.
- ready  out  1  high once out of INIT.

## Operation
- Synchroniser: two flops per bit, sync1 <= q, sync2 <= sync1.
- Filter (independent per bit):
  - A 4-bit counter increments every cycle where sync2 != filtered bit.
  - When the counter reaches FILTER, the filtered bit takes sync2 and the counter clears.
  - Any cycle where sync2 == filtered bit clears the counter.
- Natural code: nat = {q_filt[1], q_filt[1]^q_filt[0]}. The decoder keeps prev = q_filt from the previous cycle. d = (nat - nat_prev) mod 4.
- FULL=1:
  - d=1 -> inc.
  - d=3 -> dec.
  - d=0 -> nothing.
  - d=2 -> err set, no pulse.
- FULL=0:
  - nat_prev=3, nat=0 -> inc.
  - nat_prev=0, nat=3 -> dec.
  - other d=1/3 -> nothing.
  - d=2 -> err set.
- inc and dec are registered and never high together.
- err_clr:
  - Clears err on the next edge.
  - If a new illegal transition is detected in the same cycle as err_clr, set wins and err stays 1.
- FSM states:
  - RESET: while rst=1. All registers 0: sync, filter counters, q_filt, prev, inc, dec, err, ready.
  - INIT: the first 3 cycles after rst deasserts. Filter is bypassed: q_filt <= sync2, prev <= q_filt, counters held at 0. inc, dec and err are suppressed; ready=0. This prevents a spurious count or error when pins sit at a non-zero state out of reset.
  - RUN: normal operation, ready=1. Exits only via rst.
- rst asserted in any state returns to RESET on the next edge. A pulse in flight is dropped.

## Timing
- Edge numbering: pin change stable before edge E0. sync1 updates at E0, sync2 at E1.
- q_filt updates at edge E(1+FILTER), provided sync2 stays stable for FILTER consecutive cycles.
- inc/dec goes high at edge E(2+FILTER) and low at E(3+FILTER). Total pin-to-pulse latency is FILTER+2 clocks.
- Minimum legal pin dwell is FILTER+2 clocks per state. Shorter dwell may be filtered out or produce err.
- A glitch of FILTER-1 or fewer cycles seen at sync2 is fully rejected: no q_filt change, no pulse.
- The two bits filter independently. A simultaneous two-bit pin change with equal filter timing reaches q_filt in one cycle and sets err.
- ready rises at the 3rd edge after the first edge sampling rst=0.

## Test plan
1. Reset exit: FILTER=4, q=2'b11 held through and after reset -> ready=1 on 3rd edge after release, q_filt=11, no inc/dec/err pulses over 50 cycles.
2. Forward x4: FILTER=4, FULL=1, q steps 00->01->11->10->00, 10 cycles each -> exactly 4 inc pulses, each 6 edges after its pin change, dec=0; then reverse sequence -> 4 dec pulses.
3. Glitch rejection: FILTER=4, q[0] pulses high 3 cycles from 00 -> q_filt stays 00, no pulse; same pulse 4+ cycles -> q_filt=01 at E5, inc at E6.
4. x1 mode: FULL=0, two forward cycles -> 2 inc pulses, only on q 10->00; one reverse cycle -> 1 dec, on q 00->10.
5. Error: FILTER=1, q 00->11 in one step -> err=1 at E3, no inc/dec; err_clr plus a second jump in the same cycle -> err stays 1; err_clr alone -> err=0 next edge.
6. Reset mid-motion: rst asserted one cycle before an expected inc -> no inc, all outputs 0 next edge, INIT repeats, and the count resumes from the current pin state without err.

Source files
------------

// File: rtl/quad_input_stage.sv
// Quadrature encoder front end: pin synchroniser, per-bit noise filter and
// Gray-code decoder producing inc/dec pulses and a sticky illegal-step flag.
module quad_input_stage #(
    parameter int FILTER = 4,
    parameter bit FULL   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] q,
    input  logic       err_clr,
    output logic       inc,
    output logic       dec,
    output logic       err,
    output logic [1:0] q_filt,
    output logic       ready
);

    typedef enum logic [1:0] {
        S_RESET,
        S_INIT,
        S_RUN
    } state_t;

    localparam logic [3:0] FLT = 4'(FILTER);

    state_t          state;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      prev;
    logic [1:0]      init_cnt;
    logic [1:0][3:0] fcnt;

    logic [1:0] nat;
    logic [1:0] nat_prev;
    logic [1:0] d;
    logic       fwd;
    logic       rev;
    logic       bad;

    always_comb begin
        nat      = {q_filt[1], q_filt[1] ^ q_filt[0]};
        nat_prev = {prev[1], prev[1] ^ prev[0]};
        d        = nat - nat_prev;
        bad      = (d == 2'd2);
        if (FULL) begin
            fwd = (d == 2'd1);
            rev = (d == 2'd3);
        end else begin
            // x1 mode counts only the wrap through nat 3 <-> 0
            fwd = (nat_prev == 2'd3) && (nat == 2'd0);
            rev = (nat_prev == 2'd0) && (nat == 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RESET;
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            init_cnt <= '0;
            fcnt     <= '0;
            q_filt   <= '0;
            inc      <= 1'b0;
            dec      <= 1'b0;
            err      <= 1'b0;
            ready    <= 1'b0;
        end else begin
            sync1 <= q;
            sync2 <= sync1;
            inc   <= 1'b0;
            dec   <= 1'b0;
            unique case (state)
                S_RESET: begin
                    state    <= S_INIT;
                    init_cnt <= '0;
                end
                S_INIT: begin
                    // filter bypassed so pins resting non-zero load silently
                    q_filt <= sync2;
                    prev   <= q_filt;
                    fcnt   <= '0;
                    if (init_cnt == 2'd2) begin
                        state <= S_RUN;
                        ready <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 2'd1;
                    end
                end
                S_RUN: begin
                    prev <= q_filt;
                    inc  <= fwd;
                    dec  <= rev;
                    if (bad) begin
                        err <= 1'b1;
                    end else if (err_clr) begin
                        err <= 1'b0;
                    end
                    for (int i = 0; i < 2; i++) begin
                        if (sync2[i] != q_filt[i]) begin
                            if (fcnt[i] + 4'd1 == FLT) begin
                                q_filt[i] <= sync2[i];
                                fcnt[i]   <= '0;
                            end else begin
                                fcnt[i] <= fcnt[i] + 4'd1;
                            end
                        end else begin
                            fcnt[i] <= '0;
                        end
                    end
                end
                default: state <= S_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_input_stage.sv
// Directed bench for quad_input_stage: x4, x1 and FILTER=1 instances
// checked against hand-computed pulse timing.
module tb_quad_input_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_clr = 1'b0;
    logic [1:0] q_w [3];
    logic       inc_w [3];
    logic       dec_w [3];
    logic       err_w [3];
    logic [1:0] qf_w [3];
    logic       rdy_w [3];

    int n_cmp = 0;
    int n_bad = 0;
    int n_inc [3] = '{0, 0, 0};
    int n_dec [3] = '{0, 0, 0};
    int b_inc;
    int b_dec;

    always #5 clk = ~clk;

    quad_input_stage #(.FILTER(4), .FULL(1'b1)) u_x4 (
        .clk(clk), .rst(rst), .q(q_w[0]), .err_clr(err_clr),
        .inc(inc_w[0]), .dec(dec_w[0]), .err(err_w[0]),
        .q_filt(qf_w[0]), .ready(rdy_w[0])
    );

    quad_input_stage #(.FILTER(4), .FULL(1'b0)) u_x1 (
        .clk(clk), .rst(rst), .q(q_w[1]), .err_clr(err_clr),
        .inc(inc_w[1]), .dec(dec_w[1]), .err(err_w[1]),
        .q_filt(qf_w[1]), .ready(rdy_w[1])
    );

    quad_input_stage #(.FILTER(1), .FULL(1'b1)) u_f1 (
        .clk(clk), .rst(rst), .q(q_w[2]), .err_clr(err_clr),
        .inc(inc_w[2]), .dec(dec_w[2]), .err(err_w[2]),
        .q_filt(qf_w[2]), .ready(rdy_w[2])
    );

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (inc_w[i] === 1'b1) n_inc[i]++;
            if (dec_w[i] === 1'b1) n_dec[i]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // FILTER=4 move: q_filt at E5, pulse at E6, gone at E7
    task automatic move(input int u, input logic [1:0] nq,
                        input logic ei, input logic ed);
        q_w[u] = nq;
        step(6);
        chk("mv_qf", 32'(qf_w[u]), 32'(nq));
        chk("mv_pre", {30'd0, inc_w[u], dec_w[u]}, 32'd0);
        step(1);
        chk("mv_pulse", {30'd0, inc_w[u], dec_w[u]}, {30'd0, ei, ed});
        step(1);
        chk("mv_post", {30'd0, inc_w[u], dec_w[u]}, 32'd0);
        step(2);
    endtask

    task automatic snap(input int u);
        b_inc = n_inc[u];
        b_dec = n_dec[u];
    endtask

    initial begin
        q_w[0] = 2'b11;
        q_w[1] = 2'b00;
        q_w[2] = 2'b00;

        // reset exit with pins resting at 11
        step(3);
        chk("rst_qf", 32'(qf_w[0]), 32'd0);
        chk("rst_out", {28'd0, inc_w[0], dec_w[0], err_w[0], rdy_w[0]}, 32'd0);
        rst = 1'b0;
        step(1);
        chk("init_r0", 32'(rdy_w[0]), 32'd0);
        step(2);
        chk("init_r2", 32'(rdy_w[0]), 32'd0);
        step(1);
        chk("ready_r3", 32'(rdy_w[0]), 32'd1);
        chk("init_qf", 32'(qf_w[0]), 32'd3);
        snap(0);
        step(50);
        chk("idle_inc", 32'(n_inc[0] - b_inc), 32'd0);
        chk("idle_dec", 32'(n_dec[0] - b_dec), 32'd0);
        chk("idle_err", 32'(err_w[0]), 32'd0);

        // forward x4, first walking back to 00 the forward way
        move(0, 2'b10, 1'b1, 1'b0);
        move(0, 2'b00, 1'b1, 1'b0);
        snap(0);
        move(0, 2'b01, 1'b1, 1'b0);
        move(0, 2'b11, 1'b1, 1'b0);
        move(0, 2'b10, 1'b1, 1'b0);
        move(0, 2'b00, 1'b1, 1'b0);
        chk("fwd_inc", 32'(n_inc[0] - b_inc), 32'd4);
        chk("fwd_dec", 32'(n_dec[0] - b_dec), 32'd0);
        snap(0);
        move(0, 2'b10, 1'b0, 1'b1);
        move(0, 2'b11, 1'b0, 1'b1);
        move(0, 2'b01, 1'b0, 1'b1);
        move(0, 2'b00, 1'b0, 1'b1);
        chk("rev_inc", 32'(n_inc[0] - b_inc), 32'd0);
        chk("rev_dec", 32'(n_dec[0] - b_dec), 32'd4);
        chk("x4_err", 32'(err_w[0]), 32'd0);

        // 3-cycle glitch on q[0] is rejected
        snap(0);
        q_w[0] = 2'b01;
        step(3);
        q_w[0] = 2'b00;
        step(12);
        chk("glitch_qf", 32'(qf_w[0]), 32'd0);
        chk("glitch_cnt", 32'(n_inc[0] - b_inc + n_dec[0] - b_dec), 32'd0);
        move(0, 2'b01, 1'b1, 1'b0);
        move(0, 2'b00, 1'b0, 1'b1);

        // x1 mode
        snap(1);
        for (int c = 0; c < 2; c++) begin
            move(1, 2'b01, 1'b0, 1'b0);
            move(1, 2'b11, 1'b0, 1'b0);
            move(1, 2'b10, 1'b0, 1'b0);
            move(1, 2'b00, 1'b1, 1'b0);
        end
        move(1, 2'b10, 1'b0, 1'b1);
        move(1, 2'b11, 1'b0, 1'b0);
        move(1, 2'b01, 1'b0, 1'b0);
        move(1, 2'b00, 1'b0, 1'b0);
        chk("x1_inc", 32'(n_inc[1] - b_inc), 32'd2);
        chk("x1_dec", 32'(n_dec[1] - b_dec), 32'd1);

        // FILTER=1 double step and sticky error
        snap(2);
        q_w[2] = 2'b11;
        step(3);
        chk("jmp_qf", 32'(qf_w[2]), 32'd3);
        chk("jmp_e2", 32'(err_w[2]), 32'd0);
        step(1);
        chk("jmp_err", 32'(err_w[2]), 32'd1);
        step(5);
        q_w[2] = 2'b00;
        step(3);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("clr_vs_set", 32'(err_w[2]), 32'd1);
        step(3);
        chk("err_sticky", 32'(err_w[2]), 32'd1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("err_clr", 32'(err_w[2]), 32'd0);
        chk("jmp_cnt", 32'(n_inc[2] - b_inc + n_dec[2] - b_dec), 32'd0);

        // reset one cycle before the pulse
        snap(0);
        q_w[0] = 2'b01;
        step(6);
        chk("mid_qf", 32'(qf_w[0]), 32'd1);
        rst = 1'b1;
        step(1);
        chk("mid_rst", {26'd0, qf_w[0], inc_w[0], dec_w[0], err_w[0], rdy_w[0]},
            32'd0);
        rst = 1'b0;
        step(3);
        chk("mid_r2", 32'(rdy_w[0]), 32'd0);
        step(1);
        chk("mid_rdy", 32'(rdy_w[0]), 32'd1);
        chk("mid_qf2", 32'(qf_w[0]), 32'd1);
        chk("mid_drop", 32'(n_inc[0] - b_inc + n_dec[0] - b_dec), 32'd0);
        move(0, 2'b11, 1'b1, 1'b0);
        chk("mid_err", 32'(err_w[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
